// File: rtl/xconv_pkg.sv
// Shared types and helpers for the WB lane-packing upsizer.
package xconv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    ERR   = 2'd3
  } xconv_state_e;

  // Default lane width in bits.
  localparam int XC_LW = 32;

  // Widest byte-strobe vector the helper can produce; callers cast down.
  localparam int XC_STRB_MAX = 256;

  // Byte-strobe vector with the low lanes*bytes_per_lane bits set.
  function automatic logic [XC_STRB_MAX-1:0] lane_strobe(input logic [7:0] lanes,
                                                         input int bytes_per_lane);
    logic [XC_STRB_MAX-1:0] strb;
    strb = {XC_STRB_MAX{1'b0}};
    for (int i = 0; i < XC_STRB_MAX; i++) begin
      strb[i] = (i < int'(lanes) * bytes_per_lane) ? 1'b1 : 1'b0;
    end
    return strb;
  endfunction

endpackage

// File: rtl/xconv_lane_packer.sv
// Lane buffer for the upsizer: appends NS input lanes at position cnt,
// cuts a lanes_cfg-wide word when enough lanes are present and shifts the
// residual down. Lanes at or above cnt are kept zero so appends can be ORed in.
module xconv_lane_packer #(
  parameter int NS = 4,
  parameter int ND = 13,
  parameter int LW = 32,
  parameter int CW = 4
) (
  input  logic               xclk,
  input  logic               xreset_n,
  input  logic               clear,
  input  logic               accept,
  input  logic               flush_take,
  input  logic [CW-1:0]      lanes_cfg,
  input  logic [NS*LW-1:0]   in_data,
  output logic [CW-1:0]      cnt,
  output logic [CW-1:0]      cnt_acc,
  output logic               complete,
  output logic [ND*LW-1:0]   full_word,
  output logic [ND*LW-1:0]   flush_word
);

  localparam int NB = ND + NS - 1;
  localparam int BW = NB * LW;
  localparam logic [CW:0] NS_C = NS[CW:0];

  logic [BW-1:0]    lane_buf_r;
  logic [CW-1:0]    cnt_r;
  logic [BW-1:0]    merged_s;
  logic [BW-1:0]    shifted_s;
  logic [CW:0]      sum_s;
  logic [ND*LW-1:0] word_mask_s;
  logic [ND*LW-1:0] flush_mask_s;

  assign cnt = cnt_r;

  // Merge the incoming beat into the buffer and derive the outgoing words.
  always_comb begin
    sum_s    = {1'b0, cnt_r} + NS_C;
    complete = (sum_s >= {1'b0, lanes_cfg});
    if (complete) begin
      cnt_acc = CW'(sum_s - {1'b0, lanes_cfg});
    end else begin
      cnt_acc = sum_s[CW-1:0];
    end
    merged_s     = lane_buf_r | ({{(BW - NS*LW){1'b0}}, in_data} << (LW * int'(cnt_r)));
    shifted_s    = merged_s >> (LW * int'(lanes_cfg));
    word_mask_s  = ~({(ND*LW){1'b1}} << (LW * int'(lanes_cfg)));
    flush_mask_s = ~({(ND*LW){1'b1}} << (LW * int'(cnt_r)));
    full_word    = merged_s[ND*LW-1:0] & word_mask_s;
    flush_word   = lane_buf_r[ND*LW-1:0] & flush_mask_s;
  end

  // Buffer and fill-count update: clear on restart or flush, append on accept.
  always_ff @(posedge xclk or negedge xreset_n) begin
    if (!xreset_n) begin
      lane_buf_r <= {BW{1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (clear) begin
      lane_buf_r <= {BW{1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (accept) begin
      if (complete) begin
        lane_buf_r <= shifted_s;
      end else begin
        lane_buf_r <= merged_s;
      end
      cnt_r <= cnt_acc;
    end else if (flush_take) begin
      lane_buf_r <= {BW{1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else begin
      lane_buf_r <= lane_buf_r;
      cnt_r      <= cnt_r;
    end
  end

endmodule

// File: rtl/xconverter_wb_upsize_gen.sv
// Lane-packing upsizer from the DMA read stream into WB SRAM write words.
// Holds the control FSM, both handshakes and the WB address counter; the lane
// buffer lives in xconv_lane_packer.
// Optional: define XCONV_WB_UPSIZE_PERF_EN to enable the handshake/stall
// performance counters; otherwise perf_beats/perf_stalls read as zero.
module xconverter_wb_upsize_gen
  import xconv_pkg::*;
#(
  parameter int DWS   = 128,
  parameter int DWD   = 416,
  parameter int AW_WB = 13,
  parameter int LW    = XC_LW,
  localparam int NS   = DWS / LW,
  localparam int ND   = DWD / LW,
  localparam int CW   = $clog2(ND + 1)
) (
  input  logic               xclk,
  input  logic               xreset_n,
  input  logic               cfg_start,
  input  logic [AW_WB-1:0]   cfg_base_addr,
  input  logic [CW-1:0]      cfg_lanes,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DWS-1:0]     s_data,
  input  logic               s_last,
  output logic               wb_write,
  input  logic               wb_ready,
  output logic [AW_WB-1:0]   wb_addr,
  output logic [DWD/8-1:0]   wb_wstrb,
  output logic [DWD-1:0]     wb_wdata,
  output logic               busy,
  output logic               err_cfg,
  output logic [31:0]        perf_beats,
  output logic [31:0]        perf_stalls
);

  localparam int STRB_W = DWD / 8;
  localparam int BPL    = LW / 8;
  localparam logic [CW-1:0] LANES_MIN = NS[CW-1:0];
  localparam logic [CW-1:0] LANES_MAX = ND[CW-1:0];

  xconv_state_e      state_r;
  xconv_state_e      state_s;
  logic [CW-1:0]     lanes_r;
  logic              cfg_legal_s;
  logic              out_free_s;
  logic              hs_s;
  logic              accept_s;
  logic              load_full_s;
  logic              load_flush_s;
  logic [CW-1:0]     pk_cnt_s;
  logic [CW-1:0]     pk_cnt_acc_s;
  logic              pk_complete_s;
  logic [DWD-1:0]    pk_full_word_s;
  logic [DWD-1:0]    pk_flush_word_s;
  logic [STRB_W-1:0] strb_lanes_s;
  logic [STRB_W-1:0] strb_flush_s;

  assign strb_lanes_s = STRB_W'(lane_strobe(8'(lanes_r), BPL));
  assign strb_flush_s = STRB_W'(lane_strobe(8'(pk_cnt_s), BPL));

  // Handshake qualifiers; s_ready deliberately follows wb_ready combinationally.
  always_comb begin
    cfg_legal_s  = (cfg_lanes >= LANES_MIN) & (cfg_lanes <= LANES_MAX);
    out_free_s   = ~wb_write | wb_ready;
    hs_s         = wb_write & wb_ready;
    s_ready      = (state_r == RUN) & out_free_s;
    accept_s     = s_valid & s_ready & ~cfg_start;
    load_full_s  = accept_s & pk_complete_s;
    load_flush_s = (state_r == FLUSH) & (pk_cnt_s != {CW{1'b0}}) & out_free_s & ~cfg_start;
  end

  xconv_lane_packer #(
    .NS (NS),
    .ND (ND),
    .LW (LW),
    .CW (CW)
  ) u_packer (
    .xclk       (xclk),
    .xreset_n   (xreset_n),
    .clear      (cfg_start),
    .accept     (accept_s),
    .flush_take (load_flush_s),
    .lanes_cfg  (lanes_r),
    .in_data    (s_data),
    .cnt        (pk_cnt_s),
    .cnt_acc    (pk_cnt_acc_s),
    .complete   (pk_complete_s),
    .full_word  (pk_full_word_s),
    .flush_word (pk_flush_word_s)
  );

  // FSM state register.
  always_ff @(posedge xclk or negedge xreset_n) begin
    if (!xreset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: cfg_start restarts from any state.
  always_comb begin
    state_s = state_r;
    if (cfg_start) begin
      state_s = cfg_legal_s ? RUN : ERR;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        RUN: begin
          if (accept_s & s_last) begin
            state_s = (pk_cnt_acc_s != {CW{1'b0}}) ? FLUSH : IDLE;
          end else begin
            state_s = RUN;
          end
        end
        FLUSH: begin
          if ((pk_cnt_s == {CW{1'b0}}) & out_free_s) begin
            state_s = IDLE;
          end else begin
            state_s = FLUSH;
          end
        end
        ERR:     state_s = ERR;
        default: state_s = IDLE;
      endcase
    end
  end

  // Status flags and the lane count sampled at cfg_start.
  always_ff @(posedge xclk or negedge xreset_n) begin
    if (!xreset_n) begin
      busy    <= 1'b0;
      err_cfg <= 1'b0;
      lanes_r <= {CW{1'b0}};
    end else if (cfg_start) begin
      busy    <= 1'b1;
      err_cfg <= ~cfg_legal_s;
      lanes_r <= cfg_lanes;
    end else begin
      busy    <= (state_s != IDLE);
      err_cfg <= err_cfg;
      lanes_r <= lanes_r;
    end
  end

  // Output word register: load a full or flush word, hold while stalled.
  always_ff @(posedge xclk or negedge xreset_n) begin
    if (!xreset_n) begin
      wb_write <= 1'b0;
      wb_addr  <= {AW_WB{1'b0}};
      wb_wstrb <= {STRB_W{1'b0}};
      wb_wdata <= {DWD{1'b0}};
    end else if (cfg_start) begin
      wb_write <= 1'b0;
      wb_addr  <= cfg_base_addr;
      wb_wstrb <= {STRB_W{1'b0}};
      wb_wdata <= {DWD{1'b0}};
    end else begin
      if (hs_s) begin
        wb_addr <= wb_addr + {{(AW_WB-1){1'b0}}, 1'b1};
      end else begin
        wb_addr <= wb_addr;
      end
      if (load_full_s) begin
        wb_write <= 1'b1;
        wb_wstrb <= strb_lanes_s;
        wb_wdata <= pk_full_word_s;
      end else if (load_flush_s) begin
        wb_write <= 1'b1;
        wb_wstrb <= strb_flush_s;
        wb_wdata <= pk_flush_word_s;
      end else if (hs_s) begin
        wb_write <= 1'b0;
        wb_wstrb <= {STRB_W{1'b0}};
        wb_wdata <= {DWD{1'b0}};
      end else begin
        wb_write <= wb_write;
        wb_wstrb <= wb_wstrb;
        wb_wdata <= wb_wdata;
      end
    end
  end

`ifdef XCONV_WB_UPSIZE_PERF_EN
  logic stall_s;
  assign stall_s = wb_write & ~wb_ready;

  // Saturating counters of output handshakes and output stall cycles.
  always_ff @(posedge xclk or negedge xreset_n) begin
    if (!xreset_n) begin
      perf_beats  <= 32'd0;
      perf_stalls <= 32'd0;
    end else if (cfg_start) begin
      perf_beats  <= 32'd0;
      perf_stalls <= 32'd0;
    end else begin
      if (hs_s && (perf_beats != 32'hFFFF_FFFF)) begin
        perf_beats <= perf_beats + 32'd1;
      end else begin
        perf_beats <= perf_beats;
      end
      if (stall_s && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end else begin
        perf_stalls <= perf_stalls;
      end
    end
  end
`else
  assign perf_beats  = 32'd0;
  assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_xconverter_wb_upsize_gen.sv
// Self-checking bench for xconverter_wb_upsize_gen: directed scenarios plus
// randomized transfers scored against a lane-queue reference model.
module tb_xconverter_wb_upsize_gen;

  localparam int DWS = 128;
  localparam int DWD = 416;
  localparam int AW  = 13;
  localparam int LW  = 32;
  localparam int NS  = 4;
  localparam int SW  = DWD / 8;
`ifdef XCONV_WB_UPSIZE_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic            xclk = 1'b0;
  logic            xreset_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic [AW-1:0]   cfg_base_addr = '0;
  logic [3:0]      cfg_lanes = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DWS-1:0]  s_data = '0;
  logic            s_last = 1'b0;
  logic            wb_write;
  logic            wb_ready = 1'b0;
  logic [AW-1:0]   wb_addr;
  logic [SW-1:0]   wb_wstrb;
  logic [DWD-1:0]  wb_wdata;
  logic            busy;
  logic            err_cfg;
  logic [31:0]     perf_beats;
  logic [31:0]     perf_stalls;

  xconverter_wb_upsize_gen dut (
    .xclk          (xclk),
    .xreset_n      (xreset_n),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_lanes     (cfg_lanes),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .wb_write      (wb_write),
    .wb_ready      (wb_ready),
    .wb_addr       (wb_addr),
    .wb_wstrb      (wb_wstrb),
    .wb_wdata      (wb_wdata),
    .busy          (busy),
    .err_cfg       (err_cfg),
    .perf_beats    (perf_beats),
    .perf_stalls   (perf_stalls)
  );

  always #5 xclk = ~xclk;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [DWD-1:0] data;
    logic [SW-1:0]  strb;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] lane_q[$];
  int          total = 0;
  int          bad = 0;
  int          nwr = 0;
  int          cur_lanes = 0;
  logic [AW-1:0] exp_addr = '0;
  int          lane_ctr = 0;
  bit          acc_seen = 1'b0;
  bit          obs_s_ready = 1'b0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: pop n lanes off the lane queue into one expected write.
  task automatic push_word(input int n);
    wr_t w;
    w.addr = exp_addr;
    exp_addr = exp_addr + 1'b1;
    w.data = '0;
    w.strb = '0;
    for (int i = 0; i < n; i++) w.data[LW*i +: LW] = lane_q.pop_front();
    for (int b = 0; b < n * (LW / 8); b++) w.strb[b] = 1'b1;
    exp_q.push_back(w);
  endtask

  task automatic model_accept(input logic [DWS-1:0] d, input bit last);
    for (int k = 0; k < NS; k++) lane_q.push_back(d[LW*k +: LW]);
    if (lane_q.size() >= cur_lanes) push_word(cur_lanes);
    if (last && lane_q.size() > 0) push_word(lane_q.size());
  endtask

  // One clock: observe at the falling edge, score, then advance past the rise.
  task automatic tick();
    wr_t h;
    @(negedge xclk);
    obs_s_ready = s_ready;
    acc_seen = s_valid && s_ready;
    if (wb_write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 512'(wb_write), 512'(0));
      end else begin
        h = exp_q[0];
        chk("wr_addr", 512'(wb_addr), 512'(h.addr));
        chk("wr_data", 512'(wb_wdata), 512'(h.data));
        chk("wr_strb", 512'(wb_wstrb), 512'(h.strb));
        if (wb_ready) begin
          void'(exp_q.pop_front());
          nwr++;
        end
      end
    end
    if (acc_seen) model_accept(s_data, s_last);
    @(posedge xclk);
    #1;
  endtask

  task automatic cfg(input int lanes, input logic [AW-1:0] base);
    wb_ready = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    cfg_start = 1'b1;
    cfg_lanes = 4'(lanes);
    cfg_base_addr = base;
    tick();
    cfg_start = 1'b0;
    exp_q.delete();
    lane_q.delete();
    cur_lanes = lanes;
    exp_addr = base;
    lane_ctr = 0;
    nwr = 0;
  endtask

  task automatic stream(input int nb, input bit last_en, input int rdy_pct,
                        input int vld_pct, input bit inc);
    int b = 0;
    int guard = 0;
    while (b < nb && guard < 2000) begin
      s_valid = ($urandom_range(99) < vld_pct);
      s_last = last_en && (b == nb - 1);
      for (int k = 0; k < NS; k++) s_data[LW*k +: LW] = inc ? 32'(lane_ctr + k) : $urandom;
      wb_ready = ($urandom_range(99) < rdy_pct);
      tick();
      if (acc_seen) begin
        b++;
        lane_ctr += NS;
      end
      guard++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("stream_beats", 512'(b), 512'(nb));
  endtask

  task automatic drain();
    int g = 0;
    wb_ready = 1'b1;
    s_valid = 1'b0;
    while ((exp_q.size() != 0 || busy) && g < 300) begin
      tick();
      g++;
    end
    chk("drain_idle", 512'((exp_q.size() == 0) && !busy), 512'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_write"}, 512'(wb_write), 512'(0));
    chk({tag, "_wb_addr"}, 512'(wb_addr), 512'(0));
    chk({tag, "_wb_wstrb"}, 512'(wb_wstrb), 512'(0));
    chk({tag, "_wb_wdata"}, 512'(wb_wdata), 512'(0));
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_err_cfg"}, 512'(err_cfg), 512'(0));
    chk({tag, "_s_ready"}, 512'(s_ready), 512'(0));
    chk({tag, "_perf_beats"}, 512'(perf_beats), 512'(0));
    chk({tag, "_perf_stalls"}, 512'(perf_stalls), 512'(0));
  endtask

  initial begin
    int lanes;
    int nb;
    int nexp;
    logic [AW-1:0] base;

    // Reset state.
    #12;
    chk_all_zero("reset");
    @(posedge xclk);
    #1;
    xreset_n = 1'b1;

    // Full 13-lane words, incrementing lanes 0..51.
    cfg(13, 13'h100);
    chk("t1_busy", 512'(busy), 512'(1));
    stream(13, 1'b1, 100, 100, 1'b1);
    drain();
    chk("t1_writes", 512'(nwr), 512'(4));
    chk("t1_addr_end", 512'(wb_addr), 512'(13'h104));

    // 8-lane words: low 32 strobe bytes, upper lanes zero.
    cfg(8, 13'h010);
    stream(4, 1'b1, 100, 100, 1'b1);
    drain();
    chk("t2_writes", 512'(nwr), 512'(2));

    // Full word then a 7-lane flush.
    cfg(13, 13'h020);
    stream(5, 1'b1, 100, 100, 1'b1);
    drain();
    chk("t3_writes", 512'(nwr), 512'(2));
    chk("t3_addr_end", 512'(wb_addr), 512'(13'h022));

    // Output stall of five cycles with a beat waiting.
    cfg(13, 13'h040);
    stream(4, 1'b0, 100, 100, 1'b1);
    chk("stall_wb_write", 512'(wb_write), 512'(1));
    wb_ready = 1'b0;
    s_valid = 1'b1;
    s_last = 1'b1;
    for (int k = 0; k < NS; k++) s_data[LW*k +: LW] = 32'(lane_ctr + k);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_s_ready", 512'(obs_s_ready), 512'(0));
    end
    chk("stall_perf_stalls", 512'(perf_stalls), 512'(PERF_ON * 5));
    stream(1, 1'b1, 100, 100, 1'b1);
    drain();
    chk("stall_writes", 512'(nwr), 512'(2));
    chk("stall_perf_beats", 512'(perf_beats), 512'(PERF_ON * 2));

    // Illegal lane counts below and above range, then recovery.
    cfg(3, 13'h060);
    chk("err_low_flag", 512'(err_cfg), 512'(1));
    chk("err_busy", 512'(busy), 512'(1));
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_ready = 1'b1;
      tick();
      chk("err_s_ready", 512'(obs_s_ready), 512'(0));
    end
    s_valid = 1'b0;
    cfg(14, 13'h061);
    chk("err_high_flag", 512'(err_cfg), 512'(1));
    cfg(13, 13'h070);
    chk("err_cleared", 512'(err_cfg), 512'(0));

    // Abort mid-stream: two beats in, restart with a new base.
    stream(2, 1'b0, 100, 100, 1'b1);
    cfg(13, 13'h1F0);
    chk("abort_wb_write", 512'(wb_write), 512'(0));
    chk("abort_wb_addr", 512'(wb_addr), 512'(13'h1F0));

    // Randomized transfers, first one wraps the address space.
    for (int it = 0; it < 6; it++) begin
      lanes = $urandom_range(13, 4);
      base = (it == 0) ? 13'h1FFE : 13'($urandom);
      nb = $urandom_range(24, 1);
      nexp = (nb * NS + lanes - 1) / lanes;
      cfg(lanes, base);
      stream(nb, 1'b1, 70, 80, 1'b0);
      drain();
      chk("rnd_writes", 512'(nwr), 512'(nexp));
      chk("rnd_addr_end", 512'(wb_addr), 512'(13'(base + 13'(nexp))));
    end

    // Asynchronous reset while a write is stalled.
    cfg(4, 13'h300);
    stream(1, 1'b0, 0, 100, 1'b1);
    chk("areset_pending", 512'(wb_write), 512'(1));
    #2;
    xreset_n = 1'b0;
    #1;
    chk_all_zero("areset");
    exp_q.delete();
    lane_q.delete();
    @(posedge xclk);
    #1;
    xreset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xconverter_wb_upsize_gen.md
Name: xconverter_wb_upsize_gen

Overview:
- Parametrised lane-packing upsizer: packs a DWS-wide stream into DWD-wide weight-buffer (WB) SRAM writes.
- Number of valid LW-bit lanes per output word is runtime-configurable (cfg_lanes), replacing fixed 256/416 modes.
- Adds valid/ready handshakes on both sides, partial-line flush on s_last, a config error flag, and restart without reset.
- Sits between the DMA read-data path and the WB SRAM write port.

Parameters:
- DWS, 128, input data width; multiple of LW.
- DWD, 416, output data width; multiple of LW.
- AW_WB, 13, WB word-address width.
- LW, 32, lane width; derived NS=DWS/LW (4), ND=DWD/LW (13), CW=$clog2(ND+1).

Ports:
- xclk  in  1  clock.
- xreset_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  pulse: load base address, clear buffer, enter RUN.
- cfg_base_addr  in  AW_WB  first WB address.
- cfg_lanes  in  CW  lanes per output word; legal range NS..ND; sampled at cfg_start.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&s_ready.
- s_data  in  DWS  lane k = s_data[LW*k+:LW].
- s_last  in  1  last beat of transfer; flush residual.
- wb_write  out  1  output valid.
- wb_ready  in  1  SRAM accepts when wb_write&wb_ready.
- wb_addr  out  AW_WB  word address.
- wb_wstrb  out  DWD/8  byte strobes.
- wb_wdata  out  DWD  packed data.
- busy  out  1  state!=IDLE.
- err_cfg  out  1  sticky illegal cfg_lanes.
- perf_beats  out  32  see optional feature.
- perf_stalls  out  32  see optional feature.

Behaviour:
- Reset: all outputs 0; state IDLE; cnt=0; buffer cleared.
- States:
  - IDLE --cfg_start & legal--> RUN.
  - IDLE --cfg_start & illegal--> ERR; err_cfg=1; s_ready=0.
  - RUN --accept with s_last--> FLUSH if residual>0, else IDLE.
  - FLUSH --partial beat handshaken--> IDLE.
  - ERR --cfg_start & legal--> RUN, clearing err_cfg.
- Buffer: ND+NS-1 lanes; cnt<cfg_lanes is invariant in RUN.
- s_ready = (state==RUN) & (~wb_write | wb_ready). This is a combinational wb_ready->s_ready path, by design.
- Accept: the NS input lanes are appended at lane position cnt.
  - If cnt+NS >= cfg_lanes: next cycle wb_write=1, wb_wdata lanes 0..cfg_lanes-1 = buffer lanes 0..cfg_lanes-1, upper lanes 0. Residual lanes shift down; cnt <= cnt+NS-cfg_lanes.
  - Else: cnt <= cnt+NS, no write.
- Latency: one cycle from the completing accept to wb_write.
- wb_wstrb: low cfg_lanes*LW/8 bits set.
- FLUSH beat: low cnt lanes valid and strobed; the rest are zero.
- If an accept both completes a word and has s_last with residual: emit the full word first, then the FLUSH beat on a later cycle.
- Output hold: wb_wdata, wb_addr, wb_wstrb and wb_write stay stable while wb_write&~wb_ready.
- wb_addr: cfg_base_addr at cfg_start; increments by 1 after each handshake; wraps modulo 2^AW_WB.
- cfg_start in any state aborts: buffer cleared, pending wb_write dropped, new config loaded.
- Async reset mid-operation returns to reset state immediately.

Optional Feature:
- XCONV_WB_UPSIZE_PERF_EN defined:
  - perf_beats counts output handshakes.
  - perf_stalls counts cycles with wb_write&~wb_ready.
  - Both clear at cfg_start and saturate at 2^32-1.
- Undefined: both ports tied to 0, with no counter logic.

Decomposition:
- Package xconv_pkg: state enum (IDLE, RUN, FLUSH, ERR), LW default, a lane-strobe function (lanes to byte-strobe vector).
- Natural sub-module: xconv_lane_packer (buffer, append, shift-down, cnt); the top holds the FSM, handshakes and address counter.

Test Plan:
- cfg_lanes=13, base=0x100, 13 beats of incrementing lanes -> 4 writes at 0x100..0x103, all 52 strobes set, lanes 0..51 in order, cnt ends 0.
- cfg_lanes=8, 4 beats -> 2 writes, wstrb=0x...0000FFFFFFFF (low 32 bytes), upper lanes 0.
- cfg_lanes=13, 5 beats with s_last on beat 5 -> one full write, then a FLUSH write with 7 lanes (28 strobe bytes), then IDLE.
- wb_ready held 0 for 5 cycles during a write -> outputs stable, s_ready=0, perf_stalls=5 with macro defined; no data lost after release.
- cfg_lanes=3 -> err_cfg=1, s_ready=0, no writes; later cfg_start with cfg_lanes=13 clears err_cfg.
- Mid-stream: cfg_start after 2 beats -> no write emitted, wb_addr=new base; xreset_n low mid-write -> all outputs 0 in the same cycle.
